// File: rtl/iopad_rx_filter.sv
// Receive stage for the coupled pad bus: per-lane 2-flop sync, glitch filter,
// and a single-entry change-event register with a valid/ready handshake.
module iopad_rx_filter #(
   parameter int                   MAX_WIDTH     = 24,
   parameter logic [MAX_WIDTH-1:0] VALID_BITS    = 24'h00_0100,
   parameter int                   FILTER_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
   input  logic [MAX_WIDTH-1:0] iopad_fs_rx_in,
   output logic [MAX_WIDTH-1:0] filt_value,
   output logic                 evt_valid,
   input  logic                 evt_ready,
   output logic [MAX_WIDTH-1:0] evt_changed,
   output logic [MAX_WIDTH-1:0] evt_value,
   output logic                 evt_overflow
);

   localparam int CW = $clog2(FILTER_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

   logic [MAX_WIDTH-1:0] sync_d;
   logic [MAX_WIDTH-1:0] sync_q;
   logic [MAX_WIDTH-1:0] filt_q;
   logic [MAX_WIDTH-1:0] upd;
   logic [MAX_WIDTH-1:0] filt_next;
   logic [CW-1:0]        cnt [MAX_WIDTH];

   logic                 evt_valid_q;
   logic                 evt_valid_next;
   logic [MAX_WIDTH-1:0] evt_changed_q;
   logic [MAX_WIDTH-1:0] evt_changed_next;
   logic [MAX_WIDTH-1:0] evt_value_q;
   logic [MAX_WIDTH-1:0] evt_value_next;
   logic                 evt_overflow_q;
   logic                 evt_overflow_next;

   // Floating (uncoupled) lanes are masked before the first flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_d <= '0;
         sync_q <= '0;
      end else begin
         sync_d <= iopad_fs_rx_in & VALID_BITS;
         sync_q <= sync_d;
      end
   end

   always_comb begin
      upd = '0;
      for (int i = 0; i < MAX_WIDTH; i++) begin
         upd[i] = enable && VALID_BITS[i] && (sync_q[i] != filt_q[i]) && (cnt[i] == CNT_LAST);
      end
      filt_next = filt_q ^ upd;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_WIDTH; i++) begin
            cnt[i] <= '0;
         end
         filt_q <= '0;
      end else begin
         for (int i = 0; i < MAX_WIDTH; i++) begin
            if (!enable || (sync_q[i] == filt_q[i]) || upd[i]) begin
               cnt[i] <= '0;
            end else begin
               cnt[i] <= cnt[i] + 1'b1;
            end
         end
         filt_q <= filt_next;
      end
   end

   // Accept and reload can happen on the same edge; otherwise new changes merge into the pending event.
   always_comb begin
      evt_valid_next    = evt_valid_q;
      evt_changed_next  = evt_changed_q;
      evt_value_next    = evt_value_q;
      evt_overflow_next = evt_overflow_q;
      if (upd != '0) begin
         if (!evt_valid_q || evt_ready) begin
            evt_valid_next    = 1'b1;
            evt_changed_next  = upd;
            evt_value_next    = filt_next;
            evt_overflow_next = 1'b0;
         end else begin
            evt_changed_next  = evt_changed_q | upd;
            evt_value_next    = filt_next;
            evt_overflow_next = evt_overflow_q | (|(upd & evt_changed_q));
         end
      end else if (evt_valid_q && evt_ready) begin
         evt_valid_next    = 1'b0;
         evt_changed_next  = '0;
         evt_overflow_next = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid_q    <= 1'b0;
         evt_changed_q  <= '0;
         evt_value_q    <= '0;
         evt_overflow_q <= 1'b0;
      end else begin
         evt_valid_q    <= evt_valid_next;
         evt_changed_q  <= evt_changed_next;
         evt_value_q    <= evt_value_next;
         evt_overflow_q <= evt_overflow_next;
      end
   end

   assign filt_value   = filt_q;
   assign evt_valid    = evt_valid_q;
   assign evt_changed  = evt_changed_q;
   assign evt_value    = evt_value_q;
   assign evt_overflow = evt_overflow_q;

endmodule

// File: tb/tb_iopad_rx_filter.sv
// Bench for iopad_rx_filter: directed vector table, hand sequences for reset,
// and randomized traffic checked against a cycle-level behavioural model.
module tb_iopad_rx_filter;

   localparam int          W    = 24;
   localparam logic [23:0] MASK = 24'h00_0100;
   localparam int          FC   = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          enable;
   logic [W-1:0]  pad;
   logic [W-1:0]  filt_value;
   logic          evt_valid;
   logic          evt_ready;
   logic [W-1:0]  evt_changed;
   logic [W-1:0]  evt_value;
   logic          evt_overflow;

   int n_checks = 0;
   int n_fail   = 0;

   iopad_rx_filter #(.MAX_WIDTH(W), .VALID_BITS(MASK), .FILTER_CYCLES(FC)) dut (
      .clk(clk),
      .rst(rst),
      .enable(enable),
      .iopad_fs_rx_in(pad),
      .filt_value(filt_value),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_changed(evt_changed),
      .evt_value(evt_value),
      .evt_overflow(evt_overflow)
   );

   always #5 clk = ~clk;

   // Behavioural model: pad history queue gives the 2-edge sync delay,
   // per-lane run lengths implement "FC consecutive differing clocks".
   logic [W-1:0] hist[$];
   int           run[W];
   logic [W-1:0] m_filt, m_chg, m_val;
   logic         m_valid, m_ovf;

   task automatic model_reset();
      hist.delete();
      for (int i = 0; i < W; i++) run[i] = 0;
      m_filt = '0; m_chg = '0; m_val = '0; m_valid = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic model_edge();
      logic [W-1:0] s, chg, dummy;
      s   = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
      chg = '0;
      for (int i = 0; i < W; i++) begin
         if (!enable) run[i] = 0;
         else if (s[i] != m_filt[i]) begin
            run[i] = run[i] + 1;
            if (run[i] >= FC) begin
               chg[i] = 1'b1;
               run[i] = 0;
            end
         end else run[i] = 0;
      end
      m_filt = m_filt ^ chg;
      if (chg != '0) begin
         if (!m_valid || evt_ready) begin
            m_valid = 1'b1; m_chg = chg; m_val = m_filt; m_ovf = 1'b0;
         end else begin
            m_ovf = m_ovf | ((chg & m_chg) != '0);
            m_chg = m_chg | chg;
            m_val = m_filt;
         end
      end else if (m_valid && evt_ready) begin
         m_valid = 1'b0; m_chg = '0; m_ovf = 1'b0;
      end
      hist.push_back(pad & MASK);
      if (hist.size() > 4) dummy = hist.pop_front();
   endtask

   function automatic logic [3*W+1:0] dut_vec();
      return {filt_value, evt_valid, evt_changed, evt_value, evt_overflow};
   endfunction

   task automatic check(input string name, input logic [3*W+1:0] got, input logic [3*W+1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got filt=%h v=%b chg=%h val=%h ovf=%b, expected filt=%h v=%b chg=%h val=%h ovf=%b",
                  name, got[3*W+1:2*W+2], got[2*W+1], got[2*W:W+1], got[W:1], got[0],
                  exp[3*W+1:2*W+2], exp[2*W+1], exp[2*W:W+1], exp[W:1], exp[0]);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      check("model", dut_vec(), {m_filt, m_valid, m_chg, m_val, m_ovf});
   endtask

   typedef struct {
      string       name;
      logic [23:0] pad;
      logic        en;
      logic        rdy;
      int          cycles;
      logic [23:0] e_filt;
      logic        e_valid;
      logic [23:0] e_chg;
      logic [23:0] e_val;
      logic        e_ovf;
   } vec_t;

   vec_t tbl[$];

   initial begin
      // name, pad, en, rdy, cycles, filt, valid, changed, value, ovf
      tbl.push_back('{"idle50",      24'h000000, 1, 1, 50, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"rise_k4",     24'h000100, 1, 1,  5, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"rise_k5",     24'h000100, 1, 1,  1, 24'h000100, 1, 24'h000100, 24'h000100, 0});
      tbl.push_back('{"rise_acc",    24'h000100, 1, 1,  1, 24'h000100, 0, 24'h000000, 24'h000100, 0});
      tbl.push_back('{"fall",        24'h000000, 1, 1, 10, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"glitch_hi",   24'h000100, 1, 1,  3, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"glitch_end",  24'h000000, 1, 1, 10, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"stall_rise",  24'h000100, 1, 0, 10, 24'h000100, 1, 24'h000100, 24'h000100, 0});
      tbl.push_back('{"stall_fall",  24'h000000, 1, 0, 10, 24'h000000, 1, 24'h000100, 24'h000000, 1});
      tbl.push_back('{"stall_acc",   24'h000000, 1, 1,  1, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"masked_on",   24'h000208, 1, 1, 10, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"masked_off",  24'h000000, 1, 1, 10, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"dis_rise",    24'h000100, 0, 1, 10, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"reen_3",      24'h000100, 1, 1,  3, 24'h000000, 0, 24'h000000, 24'h000000, 0});
      tbl.push_back('{"reen_4",      24'h000100, 1, 1,  1, 24'h000100, 1, 24'h000100, 24'h000100, 0});
      tbl.push_back('{"reen_acc",    24'h000100, 1, 1,  1, 24'h000100, 0, 24'h000000, 24'h000100, 0});
   end

   initial begin
      rst = 1'b1; enable = 1'b0; pad = '0; evt_ready = 1'b0;
      model_reset();
      repeat (3) tick();
      check("reset_state", dut_vec(), '0);
      rst = 1'b0;

      foreach (tbl[t]) begin
         pad = tbl[t].pad; enable = tbl[t].en; evt_ready = tbl[t].rdy;
         repeat (tbl[t].cycles) tick();
         check(tbl[t].name, dut_vec(),
               {tbl[t].e_filt, tbl[t].e_valid, tbl[t].e_chg, tbl[t].e_val, tbl[t].e_ovf});
      end

      // Pending event, then asynchronous reset must drop it within the same time step.
      pad = '0; enable = 1'b1; evt_ready = 1'b0;
      repeat (8) tick();
      check("pend_before_rst", dut_vec(), {24'h000000, 1'b1, 24'h000100, 24'h000000, 1'b0});
      rst = 1'b1;
      #1;
      check("async_rst", dut_vec(), '0);
      model_reset();
      repeat (2) tick();
      rst = 1'b0;

      // Disabled filter must still allow a pending event to be accepted.
      pad = 24'h000100; evt_ready = 1'b0;
      repeat (8) tick();
      enable = 1'b0; evt_ready = 1'b1;
      tick();
      check("accept_while_dis", dut_vec(), {24'h000100, 1'b0, 24'h000000, 24'h000100, 1'b0});
      enable = 1'b1;

      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(5) == 0) pad = $urandom;
         evt_ready = ($urandom_range(3) != 0);
         enable    = ($urandom_range(19) != 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
